encoder_8x3: RTL and testbench
==============================

# encoder_8x3

Sequential 8-to-3 priority encoder with a pending-request register and a valid/acknowledge handshake; it is the return path for the 3-to-8 decoder. Eight single-cycle request lines are captured into a sticky pending set. The highest-numbered pending line is presented as a 3-bit code (A = MSB, C = LSB) with V asserted. The code is held until the consumer acknowledges it. The block sits between the request sources and the unit that drives the 3-to-8 decoder with the returned code.

## Interface
- No parameters; widths fixed at 8 request lines / 3 code bits.
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  asynchronous, active-low reset
- EN  input  1  capture enable for d0..d7; 0 = request lines ignored
- d0..d7  input  1 each  request lines, sampled on rising clk; d7 highest priority
- ACK  input  1  consumer accepts current code; meaningful only while V=1
- A, B, C  output  1 each  registered code of granted line (A MSB, C LSB)
- V  output  1  registered; code valid
- PEND  output  8  registered pending set, bit i = line di outstanding
- ERR  output  1  registered sticky lost-request flag (see Configuration)

## Operation
- Reset (rst_n=0, asynchronous): PEND=8'h00, {A,B,C}=3'b000, V=0, ERR=0, state IDLE.
- Capture: each edge with EN=1 ORs {d7..d0} into PEND. EN=0 leaves PEND unchanged except for the ACK clear.
- State IDLE (V=0):
  - Form R = PEND | (EN ? {d7..d0} : 0).
  - If R≠0 at the edge: load {A,B,C} with the index of the highest set bit of R, set V=1, go to HOLD.
  - If R=0: stay in IDLE; {A,B,C} keeps its last value.
- State HOLD (V=1):
  - {A,B,C} is frozen.
  - ACK=0: stay in HOLD.
  - ACK=1 at an edge: clear PEND[{A,B,C}], set V=0, go to IDLE.
  - Same-edge new request on the same line (di=1, EN=1): set wins, and the bit stays pending.
- ACK in IDLE is ignored.
- A higher-priority request arriving during HOLD does not pre-empt the held code. It is served on the next grant.
- Priority is fixed: 7 > 6 > … > 0. No fairness guarantee.

## Timing
- Grant latency: request seen at edge k in IDLE gives V=1 and a valid code after edge k (1 cycle).
- Release: ACK=1 at edge k gives V=0 after edge k. The next grant comes no earlier than edge k+1, so there is a minimum of one IDLE cycle between grants.
- Peak throughput: one code per 2 cycles.
- PEND reflects captures/clears one cycle after the edge; it is never combinational from d.
- All outputs are registered; there are no combinational input-to-output paths.
- rst_n asserted mid-HOLD: V drops immediately (asynchronous) and all pending requests are discarded.

## Configuration
- Macro ENCODER_8X3_ERR_EN.
- Defined: ERR is set at any edge where EN=1, di=1 and PEND[i]=1 already, and bit i is not being cleared by ACK on that edge (a duplicate request is lost). ERR stays 1 until rst_n.
- Not defined: the ERR port is present but tied to 0, and no detection logic is built.

## Test plan
- Reset: hold rst_n=0 with d=8'hFF, EN=1 -> V=0, PEND=00, {A,B,C}=000, ERR=0.
- Single request: pulse d5 one cycle in IDLE -> next cycle V=1, ABC=101, PEND=20. Then ACK=1 one cycle -> V=0, PEND=00.
- Priority + drain: pulse d1,d3,d6 together -> grants 110, then 011, then 001, each held until ACK, each separated by ≥1 cycle of V=0. PEND goes 4A→0A→02→00.
- Non-pre-emption: grant d2 (ABC=010, V=1), pulse d7 while ACK=0 -> ABC stays 010. After ACK -> next grant 111.
- EN gating and same-edge set/clear:
  - EN=0 with d4 pulsed -> no grant, PEND unchanged.
  - HOLD on line 4 with ACK=1 and d4=1 on the same edge -> PEND[4] stays 1, and the next grant is 100.
- With ENCODER_8X3_ERR_EN: pulse d0 twice while d0 is pending and unacked -> ERR=1 one cycle after the second pulse, stays 1 until reset. Without the macro, ERR stays 0.

Source files
------------

// File: rtl/encoder_8x3_if.sv
// Request/grant bundle between the request sources, the encoder and the decoder driver.
// Signal names follow the block's external pin names.
interface encoder_8x3_if;
  logic       EN;
  logic       d0, d1, d2, d3, d4, d5, d6, d7;
  logic       ACK;
  logic       A, B, C;
  logic       V;
  logic [7:0] PEND;
  logic       ERR;

  modport master (
    output EN, d0, d1, d2, d3, d4, d5, d6, d7, ACK,
    input  A, B, C, V, PEND, ERR
  );

  modport slave (
    input  EN, d0, d1, d2, d3, d4, d5, d6, d7, ACK,
    output A, B, C, V, PEND, ERR
  );
endinterface

// File: rtl/encoder_8x3.sv
// Sequential 8-to-3 priority encoder with sticky pending set and V/ACK handshake.
// Optional lost-request detection on ERR is built when ENCODER_8X3_ERR_EN is defined.
module encoder_8x3 (
  input logic           clk,
  input logic           rst_n,
  encoder_8x3_if.slave  io_bus
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e     r_state, w_state_nxt;
  logic [7:0] r_pend, w_pend_nxt;
  logic [2:0] r_code, w_code_nxt;
  logic [7:0] w_req;
  logic [7:0] w_clr;
  logic [7:0] w_cand;
  logic [2:0] w_prio;

  assign w_req = io_bus.EN ? {io_bus.d7, io_bus.d6, io_bus.d5, io_bus.d4,
                              io_bus.d3, io_bus.d2, io_bus.d1, io_bus.d0} : 8'h00;

  // Requests captured on this edge are eligible for an IDLE grant on the same edge.
  assign w_cand = r_pend | w_req;

  // Highest set bit wins: later iterations overwrite lower indices.
  always_comb begin
    w_prio = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_cand[i]) w_prio = 3'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_clr       = 8'h00;
    unique case (r_state)
      StIdle: begin
        if (|w_cand) begin
          w_code_nxt  = w_prio;
          w_state_nxt = StHold;
        end
      end
      StHold: begin
        if (io_bus.ACK) begin
          w_clr       = 8'h01 << r_code;
          w_state_nxt = StIdle;
        end
      end
    endcase
  end

  // Set beats clear when a line re-requests on the edge its grant is acked.
  assign w_pend_nxt = (r_pend & ~w_clr) | w_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_pend  <= 8'h00;
      r_code  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_code  <= w_code_nxt;
    end
  end

`ifdef ENCODER_8X3_ERR_EN
  logic r_err;
  logic w_dup;

  // A duplicate is lost only if the bit stays pending through this edge.
  assign w_dup = |(w_req & r_pend & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_dup;
    end
  end

  assign io_bus.ERR = r_err;
`else
  assign io_bus.ERR = 1'b0;
`endif

  assign io_bus.A    = r_code[2];
  assign io_bus.B    = r_code[1];
  assign io_bus.C    = r_code[0];
  assign io_bus.V    = (r_state == StHold);
  assign io_bus.PEND = r_pend;

endmodule

// File: tb/tb_encoder_8x3.sv
// Directed bench for encoder_8x3: expected grant codes are queued when requests are
// driven and popped when V is observed high.
module tb_encoder_8x3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [2:0] exp_q[$];
  logic err_exp;

  encoder_8x3_if bus ();

  encoder_8x3 u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [7:0] v);
    {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0} = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for V, then compare the code against the oldest queued expectation.
  task automatic get_grant(input string tag);
    int n;
    logic [2:0] e;
    n = 0;
    while (bus.V !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, ".v"}, {31'd0, bus.V}, 32'd1);
    chk({tag, ".sb"}, {31'd0, exp_q.size() > 0}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".code"}, {29'd0, bus.A, bus.B, bus.C}, {29'd0, e});
    end
  endtask

  task automatic ack_once();
    bus.ACK = 1'b1;
    tick();
    bus.ACK = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
`ifdef ENCODER_8X3_ERR_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    rst_n   = 1'b0;
    bus.EN  = 1'b1;
    bus.ACK = 1'b0;
    set_d(8'hFF);
    tick();
    tick();
    chk("rst.v", {31'd0, bus.V}, 32'd0);
    chk("rst.pend", {24'd0, bus.PEND}, 32'h00);
    chk("rst.code", {29'd0, bus.A, bus.B, bus.C}, 32'd0);
    chk("rst.err", {31'd0, bus.ERR}, 32'd0);
    set_d(8'h00);
    rst_n = 1'b1;
    tick();

    // Single request on line 5.
    set_d(8'h20);
    exp_q.push_back(3'b101);
    tick();
    set_d(8'h00);
    get_grant("single");
    chk("single.pend", {24'd0, bus.PEND}, 32'h20);
    ack_once();
    chk("single.rel.v", {31'd0, bus.V}, 32'd0);
    chk("single.rel.pend", {24'd0, bus.PEND}, 32'h00);

    // Priority and drain of lines 1, 3, 6.
    set_d(8'h4A);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b001);
    tick();
    set_d(8'h00);
    get_grant("drain6");
    chk("drain6.pend", {24'd0, bus.PEND}, 32'h4A);
    ack_once();
    chk("drain6.gap", {31'd0, bus.V}, 32'd0);
    chk("drain6.rel.pend", {24'd0, bus.PEND}, 32'h0A);
    tick();
    get_grant("drain3");
    ack_once();
    chk("drain3.gap", {31'd0, bus.V}, 32'd0);
    chk("drain3.rel.pend", {24'd0, bus.PEND}, 32'h02);
    tick();
    get_grant("drain1");
    ack_once();
    chk("drain1.rel.pend", {24'd0, bus.PEND}, 32'h00);
    tick();
    chk("drain.idle.v", {31'd0, bus.V}, 32'd0);

    // Non-pre-emption: d7 during HOLD on line 2.
    set_d(8'h04);
    exp_q.push_back(3'b010);
    tick();
    set_d(8'h00);
    get_grant("npe2");
    set_d(8'h80);
    tick();
    set_d(8'h00);
    chk("npe.hold.code", {29'd0, bus.A, bus.B, bus.C}, 32'd2);
    chk("npe.hold.v", {31'd0, bus.V}, 32'd1);
    chk("npe.hold.pend", {24'd0, bus.PEND}, 32'h84);
    ack_once();
    chk("npe.rel.pend", {24'd0, bus.PEND}, 32'h80);
    exp_q.push_back(3'b111);
    tick();
    get_grant("npe7");
    ack_once();
    chk("npe7.rel.pend", {24'd0, bus.PEND}, 32'h00);

    // EN gating.
    bus.EN = 1'b0;
    set_d(8'h10);
    tick();
    bus.EN = 1'b1;
    set_d(8'h00);
    chk("en0.v", {31'd0, bus.V}, 32'd0);
    chk("en0.pend", {24'd0, bus.PEND}, 32'h00);
    tick();
    chk("en0.v2", {31'd0, bus.V}, 32'd0);

    // Same-edge set and clear on line 4.
    set_d(8'h10);
    exp_q.push_back(3'b100);
    tick();
    set_d(8'h00);
    get_grant("sc4a");
    set_d(8'h10);
    bus.ACK = 1'b1;
    exp_q.push_back(3'b100);
    tick();
    bus.ACK = 1'b0;
    set_d(8'h00);
    chk("sc.v", {31'd0, bus.V}, 32'd0);
    chk("sc.pend", {24'd0, bus.PEND}, 32'h10);
    chk("sc.err", {31'd0, bus.ERR}, 32'd0);
    tick();
    get_grant("sc4b");
    ack_once();
    chk("sc.rel.pend", {24'd0, bus.PEND}, 32'h00);

    // Duplicate request on line 0 while pending.
    set_d(8'h01);
    exp_q.push_back(3'b000);
    tick();
    set_d(8'h00);
    get_grant("dup0");
    chk("dup.err.pre", {31'd0, bus.ERR}, 32'd0);
    set_d(8'h01);
    tick();
    set_d(8'h00);
    chk("dup.err", {31'd0, bus.ERR}, {31'd0, err_exp});
    ack_once();
    tick();
    tick();
    chk("dup.err.sticky", {31'd0, bus.ERR}, {31'd0, err_exp});
    chk("dup.pend", {24'd0, bus.PEND}, 32'h00);

    // Asynchronous reset in the middle of HOLD.
    set_d(8'h88);
    exp_q.push_back(3'b111);
    tick();
    set_d(8'h00);
    get_grant("arst7");
    rst_n = 1'b0;
    #1;
    chk("arst.v", {31'd0, bus.V}, 32'd0);
    chk("arst.pend", {24'd0, bus.PEND}, 32'h00);
    chk("arst.err", {31'd0, bus.ERR}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst.idle.v", {31'd0, bus.V}, 32'd0);
    chk("sb.empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
